// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher
//  Description : Turns a one-cycle event (rising edge on entrada) into a
//                fixed-width high level on salida, followed by a forced-low
//                guard gap. One further event can wait in a pending slot;
//                events arriving while that slot is full are reported on
//                dropped.
//  Ports       : clk      in  system clock, all state on posedge
//                reset    in  asynchronous, active-high reset
//                entrada  in  event request, rising edge detected internally
//                salida   out stretched output level (registered)
//                busy     out high while in ACTIVE or GUARD (registered)
//                dropped  out one-cycle pulse, event lost (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_stretcher #(
   parameter int HOLD_CYCLES  = 5,  // cycles salida stays high per event (>=1)
   parameter int GUARD_CYCLES = 5,  // cycles salida is forced low after a hold (>=1)
   parameter int CNT_W        = 8   // 2**CNT_W > max(HOLD_CYCLES, GUARD_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic entrada,
   output logic salida,
   output logic busy,
   output logic dropped
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACTIVE = 2'd1;
   localparam logic [1:0] c_GUARD  = 2'd2;

   localparam logic [CNT_W-1:0] c_HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pending;
   logic             r_prev;
   logic             r_salida;
   logic             r_busy;
   logic             r_dropped;

   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_pending_nxt;
   logic             w_salida_nxt;
   logic             w_busy_nxt;
   logic             w_dropped_nxt;
   logic             w_ev;
   logic             w_guard_exit;

   assign w_ev         = entrada & ~r_prev;
   // Last GUARD cycle: the pending slot (or a fresh event) is consumed here,
   // so an event in this cycle is merged rather than queued or dropped.
   assign w_guard_exit = (r_state == c_GUARD) && (r_cnt == '0);

   // ------------------------------------------------------------------------
   // State register (also holds counter, pending slot and registered outputs)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= c_IDLE;
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_prev    <= 1'b0;
         r_salida  <= 1'b0;
         r_busy    <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
         r_prev    <= entrada;
         r_salida  <= w_salida_nxt;
         r_busy    <= w_busy_nxt;
         r_dropped <= w_dropped_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      case (r_state)
         c_IDLE: begin
            if (w_ev) begin
               w_state_nxt = c_ACTIVE;
               w_cnt_nxt   = c_HOLD_LOAD;
            end
         end
         c_ACTIVE: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - c_CNT_ONE;
            end else begin
               w_state_nxt = c_GUARD;
               w_cnt_nxt   = c_GUARD_LOAD;
            end
            if (w_ev && !r_pending) begin
               w_pending_nxt = 1'b1;
            end
         end
         c_GUARD: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - c_CNT_ONE;
               if (w_ev && !r_pending) begin
                  w_pending_nxt = 1'b1;
               end
            end else if (r_pending || w_ev) begin
               w_state_nxt   = c_ACTIVE;
               w_cnt_nxt     = c_HOLD_LOAD;
               w_pending_nxt = 1'b0;
            end else begin
               w_state_nxt = c_IDLE;
            end
         end
         default: begin
            w_state_nxt   = c_IDLE;
            w_cnt_nxt     = '0;
            w_pending_nxt = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic (values registered on the next edge)
   // ------------------------------------------------------------------------
   always_comb begin
      w_salida_nxt  = (w_state_nxt == c_ACTIVE);
      w_busy_nxt    = (w_state_nxt != c_IDLE);
      // Pending is only ever set outside IDLE, so a full slot implies busy.
      w_dropped_nxt = w_ev && r_pending && !w_guard_exit &&
                      ((r_state == c_ACTIVE) || (r_state == c_GUARD));
   end

   assign salida  = r_salida;
   assign busy    = r_busy;
   assign dropped = r_dropped;

endmodule
`default_nettype wire
